lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store unit that sits between the MIPS pipeline's memory stage and the word-addressed data memory.
- Accepts byte/halfword/word load and store requests on a valid/ready handshake and checks alignment and range.
- Drives the data memory's write-enable, address and write-data port and samples its combinational read data.
- Sub-word stores are done as read-modify-write. Returns extended load data or an error on a valid/ready response channel.

Parameters:
ADDR_W, 32, width of request byte address and memory address port
DATA_W, 32, data word width (fixed 32; byte lanes = DATA_W/8)
MEM_WORDS, 64, number of words in attached data memory; word index >= MEM_WORDS is out of range

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads: sign-extend when 1, zero-extend when 0
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size, or out of range
mem_we  out  1  memory write enable
mem_address  out  ADDR_W  word index (req_addr >> 2)
mem_writeData  out  DATA_W  full word to write
mem_readData  in  DATA_W  combinational memory read data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset state: state IDLE. req_ready=1 in IDLE after reset. resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_address=0, mem_writeData=0.
- States: IDLE, ACCESS, WRITE, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid&req_ready, capture we/size/signed/addr/wdata.
  - Error if any of: size==11; half with addr[0]!=0; word with addr[1:0]!=0; addr>>2 >= MEM_WORDS. Error -> RESP with resp_err=1, no memory access.
  - Load or sub-word store -> ACCESS.
  - Word store -> WRITE.
- ACCESS (1 cycle): mem_address=captured word index, mem_we=0. Register mem_readData at end of cycle.
  - Load -> RESP with extracted, extended data.
  - Sub-word store -> WRITE with merged word.
- WRITE (1 cycle): mem_we=1, mem_address=word index, mem_writeData=merged word (word store: wdata). -> RESP, rdata=0, err=0.
- RESP: resp_valid=1; resp_rdata/resp_err held stable until resp_ready. Handshake -> IDLE. New requests are not accepted while in RESP.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; half at addr[1]*16.
  - Merge replaces only the addressed lane(s) with the low bits of wdata.
  - Extract right-justifies, then sign- or zero-extends.
- Latency from acceptance edge to resp_valid high:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Outside ACCESS/WRITE, mem_address=0, mem_writeData=0, mem_we=0.
- mem_we = (state==WRITE) & rst_n. Reset asserted during WRITE must suppress the write in that same cycle, because memory writes on the falling edge.
- Reset mid-operation: abort to IDLE, drop any captured request, no response issued.
- Max one outstanding request; no pipelining.

Decomposition:
- Shared package lsu_pkg:
  - size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum lsu_state_t
  - function for misalignment check
- Sub-module lsu_lane_unit: combinational lane merge (store) and lane extract/extend (load). It is reused by the unit and the bench model.

Test Plan:
- Word store 0xDEADBEEF at 0x10, then signed lw 0x10 -> one-cycle mem_we pulse with mem_address=4, mem_writeData=0xDEADBEEF; load resp_rdata=0xDEADBEEF, resp_err=0, resp 2 cycles after each accept.
- Word 4 preloaded 0x11223344; sb 0xAA at 0x11 -> ACCESS then WRITE of 0x1122AA44 (3-cycle latency); lb signed 0x11 -> 0xFFFFFFAA; lb unsigned 0x11 -> 0x000000AA.
- Word 4 = 0x80017FFF; lh signed 0x12 -> 0xFFFF8001; lh signed 0x10 -> 0x00007FFF; lhu 0x12 -> 0x00008001.
- lw 0x06, lh 0x03, size=11, and lw 0x100 -> each resp_err=1 one cycle after accept, resp_rdata=0, mem_we never asserted.
- resp_ready held low 3 cycles after load response -> resp_valid/resp_rdata stable, req_ready=0, concurrent req_valid ignored; release -> IDLE, next request accepted.
- rst_n low during WRITE of sb 0x55 at 0x20 -> mem_we=0 that cycle, memory word 8 unchanged, next cycle state IDLE, resp_valid=0, req_ready=1 after rst_n high.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, alignment check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  // Bytes never misalign; an illegal size is flagged separately.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = |offset;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Little-endian byte-lane merge (stores) and extract/extend (loads); purely combinational.
// Zero latency; no flow control.
module lsu_lane_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              sgn,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] extracted
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    merged    = old_word;
    extracted = '0;
    byte_lane = old_word[{offset, 3'b000} +: 8];
    half_lane = old_word[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
        extracted = {{(DATA_W-8){sgn & byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        extracted = {{(DATA_W-16){sgn & half_lane[15]}}, half_lane};
      end
      default: begin
        merged    = wdata;
        extracted = old_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit to word-addressed data memory; latency err 1, load/sw 2, sub-word store 3 (RMW).
// One request in flight: req_ready only in IDLE; response held until resp_ready.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData
);

  lsu_state_t        state_q, state_d;
  logic              we_q, sgn_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, wr_word_q, rdata_q;
  logic [DATA_W-1:0] lane_merged, lane_extracted;
  logic              accept, req_err;
  logic [ADDR_W-1:0] word_idx_q;

  assign accept     = req_valid & req_ready;
  assign word_idx_q = {2'b00, addr_q[ADDR_W-1:2]};
  assign req_err    = (req_size == SZ_ILL)
                    | is_misaligned(req_size, req_addr[1:0])
                    | ((req_addr >> 2) >= ADDR_W'(MEM_WORDS));

  lsu_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sgn       (sgn_q),
    .old_word  (mem_readData),
    .wdata     (wdata_q),
    .merged    (lane_merged),
    .extracted (lane_extracted)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_err      = 1'b0;
    mem_we        = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)                          state_d = ST_RESP;
          else if (req_we && req_size == SZ_WORD) state_d = ST_WRITE;
          else                                  state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_address = word_idx_q;
        state_d     = we_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        // Memory commits on the falling edge, so reset must kill the strobe combinationally.
        mem_we        = rst_n;
        mem_address   = word_idx_q;
        mem_writeData = wr_word_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        we_q      <= req_we;
        sgn_q     <= req_signed;
        err_q     <= req_err;
        size_q    <= req_size;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        wr_word_q <= req_wdata;
        rdata_q   <= '0;
      end
      if (state_q == ST_ACCESS) begin
        if (we_q) wr_word_q <= lane_merged;
        else      rdata_q   <= lane_extracted;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized self-checking bench for lsu_mem_initiator against an arithmetic reference model.
module tb_lsu_mem_initiator;

  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_address, mem_writeData, mem_readData;

  logic [31:0] mem     [MW];
  logic [31:0] ref_mem [MW];
  int          n_cmp = 0, n_bad = 0, we_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;

  lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  assign mem_readData = (mem_address < 32'(MW)) ? mem[mem_address[5:0]] : 32'h0;

  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_address[5:0]] <= mem_writeData;
      we_cnt     <= we_cnt + 1;
      last_waddr <= mem_address;
      last_wdata <= mem_writeData;
    end
    if (pl_en) mem[pl_idx] <= pl_dat;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pl_idx = idx[5:0];
    pl_dat = v;
    pl_en  = 1'b1;
    @(negedge clk);
    #1 pl_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  task automatic do_txn(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold);
    int          idx, nb, sh, lat, w0, t, exp_lat, exp_we;
    logic        err;
    logic [31:0] mask, old, exp_rd, newv;
    idx    = int'(addr >> 2);
    err    = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)
             || (idx >= MW);
    exp_rd = 32'h0;
    newv   = 32'h0;
    exp_we = 0;
    if (err)                       exp_lat = 1;
    else if (we && sz == 2'b01)    exp_lat = 3;
    else if (we && sz == 2'b00)    exp_lat = 3;
    else                           exp_lat = 2;
    if (!err) begin
      nb   = 1 << sz;
      sh   = 8 * int'(addr[1:0]);
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      old  = ref_mem[idx];
      if (we) begin
        newv = (old & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[idx] = newv;
        exp_we = 1;
      end else begin
        exp_rd = (old >> sh) & mask;
        if (sg && exp_rd[8 * nb - 1]) exp_rd = exp_rd | ~mask;
      end
    end

    t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    w0 = we_cnt;
    req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("resp_rdata", resp_rdata, exp_rd);
    if (hold > 0) begin
      resp_ready = 1'b0;
      req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'hCAFE_0000;
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_rdata", resp_rdata, exp_rd);
        chk("hold_err", 32'(resp_err), 32'(err));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    chk("we_pulses", 32'(we_cnt - w0), 32'(exp_we));
    if (exp_we != 0) begin
      chk("wr_addr", last_waddr, 32'(idx));
      chk("wr_data", last_wdata, newv);
    end
    if (!err) chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int          w0;
    logic        we, sg;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < MW; i++) preload(i, $urandom);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_writeData, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    do_txn(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 0);
    chk("sw_lw_result", mem[4], 32'hDEAD_BEEF);

    preload(4, 32'h1122_3344);
    do_txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 0);
    chk("sb_merge", mem[4], 32'h1122_AA44);
    do_txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
    do_txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0);

    preload(4, 32'h8001_7FFF);
    do_txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
    do_txn(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
    do_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);

    do_txn(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0);
    do_txn(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 0);
    do_txn(1'b1, 2'b11, 1'b0, 32'h00, 32'h1234, 0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0);

    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3);
    do_txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);

    // Abort a byte store in its write cycle; the word must survive untouched.
    w0 = we_cnt;
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    chk("abort_access_we", 32'(mem_we), 32'd0);
    chk("abort_access_addr", mem_address, 32'd8);
    @(posedge clk); #1;
    chk("abort_write_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1 chk("abort_we_in_reset", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_wdata", mem_writeData, 32'd0);
    rst_n = 1'b1;
    #1 chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("abort_no_write", 32'(we_cnt - w0), 32'd0);
    chk("abort_word8", mem[8], ref_mem[8]);

    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(256, 4095))
                                          : 32'($urandom_range(0, 255));
      if (sz != 2'b11 && $urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << sz) - 32'd1);
      do_txn(we, sz, sg, addr, $urandom,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
